// File: rtl/div4_seq.sv
// ---------------------------------------------------------------------------
// div4_seq -- sequential 4-bit unsigned restoring divider
//
// Produces one quotient bit per clock. Each trial subtraction runs through one
// rca4s ripple-carry adder in subtract mode. Operands are taken over an
// input valid/ready handshake. Quotient, remainder and the divide-by-zero flag
// are returned over an output valid/ready handshake.
//
// Handshake rule, for both interfaces: a transfer happens on a rising clk
// edge where valid and ready are both high. valid must not depend on ready.
// in_ready is high only in IDLE. out_valid is high only in DONE. The two
// handshakes therefore never happen in the same cycle.
//
// Ports
//   clk        in   1  clock; all state updates on the rising edge
//   rst        in   1  synchronous, active-high reset
//   in_valid   in   1  dividend/divisor valid
//   in_ready   out  1  operands can be accepted (IDLE only)
//   dividend   in   4  unsigned numerator N
//   divisor    in   4  unsigned denominator D
//   out_valid  out  1  quotient/remainder/div0 valid
//   out_ready  in   1  downstream accepts the result
//   quotient   out  4  floor(N/D), or DIV0_Q when D == 0
//   remainder  out  4  N mod D, or N when D == 0
//   div0       out  1  result came from a divide-by-zero
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// rca4s -- 4-bit ripple-carry adder/subtractor
//
// With subtract = 1 it computes a + ~b + 1 = a - b. In that mode cout = 1
// means no borrow occurred, so a >= b.
//
// Ports
//   a         in   4  first operand
//   b         in   4  second operand (inverted when subtracting)
//   subtract  in   1  1: a - b, 0: a + b
//   sum       out  4  result bits
//   cout      out  1  carry out of bit 3 (inverted borrow when subtracting)
// ---------------------------------------------------------------------------
module rca4s (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       subtract,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] b_eff;
  logic [4:0] carry;

  // Two's-complement subtraction: invert b and feed in a carry of 1.
  assign b_eff    = b ^ {4{subtract}};
  assign carry[0] = subtract;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
  end

  assign cout = carry[4];

endmodule

module div4_seq #(
  parameter logic [3:0] DIV0_Q = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div0
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] rem_r;   // partial remainder R
  logic [3:0] quo_r;   // dividend bits shifting out, quotient bits shifting in
  logic [3:0] dvs_r;   // latched divisor
  logic [1:0] cnt;     // remaining CALC cycles minus one

  logic [3:0] trial_a;
  logic [3:0] trial_diff;
  logic       trial_ge;
  logic [3:0] next_rem;
  logic [3:0] next_quo;

  // Shift the next dividend bit into the remainder. Before a shift the
  // remainder is below the divisor and within the consumed dividend prefix,
  // so it is at most 7. The shifted value therefore fits in 4 bits, and no
  // fifth remainder bit is needed.
  assign trial_a = {rem_r[2:0], quo_r[3]};

  rca4s u_rca (
    .a        (trial_a),
    .b        (dvs_r),
    .subtract (1'b1),
    .sum      (trial_diff),
    .cout     (trial_ge)
  );

  // Restoring step: keep the difference only when no borrow occurred.
  assign next_rem = trial_ge ? trial_diff : trial_a;
  assign next_quo = {quo_r[2:0], trial_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem_r     <= 4'd0;
      quo_r     <= 4'd0;
      dvs_r     <= 4'd0;
      cnt       <= 2'd0;
      quotient  <= 4'd0;
      remainder <= 4'd0;
      div0      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (divisor != 4'd0) begin
              quo_r <= dividend;
              rem_r <= 4'd0;
              dvs_r <= divisor;
              cnt   <= 2'd3;
              div0  <= 1'b0;
              state <= CALC;
            end else begin
              // Divide-by-zero skips CALC and reports immediately.
              quotient  <= DIV0_Q;
              remainder <= dividend;
              div0      <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        CALC: begin
          rem_r <= next_rem;
          quo_r <= next_quo;
          if (cnt == 2'd0) begin
            quotient  <= next_quo;
            remainder <= next_rem;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end

        DONE: begin
          // Results stay frozen until downstream takes them.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div4_seq.sv
// ---------------------------------------------------------------------------
// tb_div4_seq -- self-checking bench for div4_seq
// Runs a table of directed vectors, then reset and stall corner sequences,
// then every (N, D) pair with random output stalls.
// ---------------------------------------------------------------------------
module tb_div4_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] dividend = 4'd0;
  logic [3:0] divisor = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div0;

  int total = 0;
  int bad = 0;

  div4_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout required finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // One full operation: accept, measure latency, optionally stall the output,
  // then complete the output handshake.
  task automatic do_op(input logic [3:0] n, input logic [3:0] d, input int stall,
                       input logic [3:0] eq, input logic [3:0] er, input logic ed,
                       input int elat, input string tag);
    int w;
    int lat;
    bit seen;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check({tag, " in_ready_before"}, in_ready, 1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    dividend  = n;
    divisor   = d;
    tick();                          // accept edge
    in_valid  = 1'b0;
    dividend  = ~n;                  // later changes must be ignored
    divisor   = d + 4'd5;
    check({tag, " in_ready_after_accept"}, in_ready, 0);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      if (lat > 0) tick();
      else tick();
      lat++;
      if (out_valid) seen = 1;
    end
    check({tag, " latency"}, lat, elat);
    if (!seen) return;
    for (int s = 0; s < stall; s++) begin
      check({tag, " stall_valid"}, out_valid, 1);
      check({tag, " stall_in_ready"}, in_ready, 0);
      check({tag, " stall_q"}, quotient, eq);
      check({tag, " stall_r"}, remainder, er);
      tick();
    end
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div0"}, div0, ed);
    out_ready = 1'b1;
    tick();                          // output handshake edge
    out_ready = 1'b0;
    check({tag, " valid_dropped"}, out_valid, 0);
    check({tag, " idle_ready"}, in_ready, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] n;
    logic [3:0] d;
    int         stall;
    logic [3:0] q;
    logic [3:0] r;
    logic       d0;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'd13, 4'd3,  0, 4'd4,  4'd1,  1'b0, 4};
    vecs[1] = '{4'd15, 4'd1,  0, 4'd15, 4'd0,  1'b0, 4};
    vecs[2] = '{4'd7,  4'd9,  0, 4'd0,  4'd7,  1'b0, 4};
    vecs[3] = '{4'd15, 4'd15, 0, 4'd1,  4'd0,  1'b0, 4};
    vecs[4] = '{4'd5,  4'd0,  0, 4'hF,  4'd5,  1'b1, 1};
    vecs[5] = '{4'd14, 4'd4,  3, 4'd3,  4'd2,  1'b0, 4};
    vecs[6] = '{4'd9,  4'd2,  0, 4'd4,  4'd1,  1'b0, 4};
    vecs[7] = '{4'd0,  4'd7,  1, 4'd0,  4'd0,  1'b0, 4};
    vecs[8] = '{4'd1,  4'd1,  0, 4'd1,  4'd0,  1'b0, 4};
    vecs[9] = '{4'd8,  4'd0,  2, 4'hF,  4'd8,  1'b1, 1};

    // ---- reset state ----
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset div0", div0, 0);

    // ---- directed table (entries 5->6 are the stall + back-to-back pair) ----
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].n, vecs[i].d, vecs[i].stall, vecs[i].q, vecs[i].r,
            vecs[i].d0, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // ---- reset during the 2nd CALC cycle of 11/3 ----
    begin
      int pulses;
      in_valid = 1'b1;
      dividend = 4'd11;
      divisor  = 4'd3;
      tick();                        // accept edge
      in_valid = 1'b0;
      tick();                        // 1st CALC edge
      rst = 1'b1;
      tick();                        // reset taken in the 2nd CALC cycle
      rst = 1'b0;
      check("midreset in_ready", in_ready, 1);
      check("midreset out_valid", out_valid, 0);
      check("midreset quotient", quotient, 0);
      check("midreset remainder", remainder, 0);
      check("midreset div0", div0, 0);
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (out_valid) pulses++;
      end
      check("midreset no_result", pulses, 0);
      do_op(4'd11, 4'd3, 0, 4'd3, 4'd2, 1'b0, 4, "after_reset");
    end

    // ---- exhaustive sweep with random output stalls ----
    for (int n = 0; n < 16; n++) begin
      for (int d = 0; d < 16; d++) begin
        logic [3:0] eq;
        logic [3:0] er;
        logic       ed;
        int         elat;
        if (d == 0) begin
          eq = 4'hF;
          er = 4'(n);
          ed = 1'b1;
          elat = 1;
        end else begin
          eq = 4'(n / d);
          er = 4'(n % d);
          ed = 1'b0;
          elat = 4;
        end
        do_op(4'(n), 4'(d), int'($urandom_range(0, 2)), eq, er, ed, elat,
              $sformatf("ex_n%0d_d%0d", n, d));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
